// File: rtl/range_finder_arbiter.sv
// Round-robin shared min/max range engine: grants one requester per burst, tracks min/max/count
// of its samples and returns max-min with the owner id over a valid/ready result port.
module range_finder_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  output logic [NREQ-1:0]       gnt,
  input  logic [NREQ-1:0]       s_valid,
  input  logic [NREQ*WIDTH-1:0] s_data,
  input  logic [NREQ-1:0]       s_last,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [WIDTH-1:0]      r_range,
  output logic [IDW-1:0]        r_id,
  output logic [WIDTH-1:0]      r_count,
  output logic                  r_error
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FIRST, RUN, RESULT} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d, id_q, id_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] min_q, min_d, max_q, max_d, cnt_q, cnt_d;
  logic [TW-1:0]    idle_q, idle_d;
  logic             r_valid_q, r_valid_d, r_error_q, r_error_d;
  logic [WIDTH-1:0] r_range_q, r_range_d, r_count_q, r_count_d;
  logic [IDW-1:0]   r_id_q, r_id_d;

  logic             sv_s, sl_s, timeout_s;
  logic [WIDTH-1:0] smp_s, new_min_s, new_max_s, cnt_inc_s;
  logic [IDW:0]     pick_s;

  // Returns {found, id}: first set request at or after ptr, wrapping around.
  function automatic logic [IDW:0] pick_next(input logic [NREQ-1:0] r, input logic [IDW-1:0] ptr);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NREQ;
      if (r[idx]) res = {1'b1, IDW'(idx)};
    end
    return res;
  endfunction

  assign pick_s    = pick_next(req, rr_q);
  assign sv_s      = s_valid[id_q];
  assign sl_s      = s_last[id_q];
  assign smp_s     = s_data[id_q*WIDTH +: WIDTH];
  assign new_min_s = (smp_s < min_q) ? smp_s : min_q;
  assign new_max_s = (smp_s > max_q) ? smp_s : max_q;
  assign cnt_inc_s = (cnt_q == {WIDTH{1'b1}}) ? cnt_q : cnt_q + WIDTH'(1);
  assign timeout_s = (TIMEOUT != 0) && !sv_s && (idle_q == TO_LAST);

  // Next-state logic for arbitration, burst tracking and the result port.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    gnt_d     = gnt_q;
    min_d     = min_q;
    max_d     = max_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    r_valid_d = r_valid_q;
    r_range_d = r_range_q;
    r_id_d    = r_id_q;
    r_count_d = r_count_q;
    r_error_d = r_error_q;
    case (state_q)
      IDLE: begin
        if (pick_s[IDW]) begin
          id_d    = pick_s[IDW-1:0];
          gnt_d   = NREQ'(1) << pick_s[IDW-1:0];
          idle_d  = '0;
          state_d = FIRST;
        end else begin
          state_d = IDLE;
        end
      end
      FIRST, RUN: begin
        if (sv_s) begin
          min_d  = (state_q == FIRST) ? smp_s : new_min_s;
          max_d  = (state_q == FIRST) ? smp_s : new_max_s;
          cnt_d  = (state_q == FIRST) ? WIDTH'(1) : cnt_inc_s;
          idle_d = '0;
          if (sl_s) begin
            gnt_d     = '0;
            r_valid_d = 1'b1;
            r_id_d    = id_q;
            r_error_d = 1'b0;
            r_range_d = (state_q == FIRST) ? WIDTH'(0) : (new_max_s - new_min_s);
            r_count_d = (state_q == FIRST) ? WIDTH'(1) : cnt_inc_s;
            state_d   = RESULT;
          end else begin
            state_d = RUN;
          end
        end else if (timeout_s) begin
          // Abort: report samples seen so far (none if still waiting for the first one).
          gnt_d     = '0;
          r_valid_d = 1'b1;
          r_id_d    = id_q;
          r_error_d = 1'b1;
          r_range_d = '0;
          r_count_d = (state_q == FIRST) ? WIDTH'(0) : cnt_q;
          state_d   = RESULT;
        end else begin
          idle_d = idle_q + TW'(1);
        end
      end
      RESULT: begin
        if (r_ready) begin
          r_valid_d = 1'b0;
          rr_d      = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
          state_d   = IDLE;
        end else begin
          state_d = RESULT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      id_q      <= '0;
      gnt_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      cnt_q     <= '0;
      idle_q    <= '0;
      r_valid_q <= 1'b0;
      r_range_q <= '0;
      r_id_q    <= '0;
      r_count_q <= '0;
      r_error_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      id_q      <= id_d;
      gnt_q     <= gnt_d;
      min_q     <= min_d;
      max_q     <= max_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      r_valid_q <= r_valid_d;
      r_range_q <= r_range_d;
      r_id_q    <= r_id_d;
      r_count_q <= r_count_d;
      r_error_q <= r_error_d;
    end
  end

  assign gnt     = gnt_q;
  assign r_valid = r_valid_q;
  assign r_range = r_range_q;
  assign r_id    = r_id_q;
  assign r_count = r_count_q;
  assign r_error = r_error_q;

endmodule
